reg_share_ctrl: RTL and testbench

Round-robin write controller that shares one `four_bit_reg`-style storage register among several requesters. Each requester presents a request, data and an operation (load or clear). The block grants one requester at a time, captures its data and drives the register's `load`/`clear`/`d` inputs for exactly one cycle. It then acknowledges the requester. The block sits between the requester logic and the shared register; the register's `q` is read directly by all consumers and does not pass through this block.

---
 rtl/reg_share_ctrl_if.sv | 36 +++
 rtl/reg_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_reg_share_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_share_ctrl_if.sv
// ============================================================================
// Module      : reg_share_ctrl_if
// Description : Requester-side bus of the shared-register write controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_share_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) ();
    localparam int c_OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       op_clr;
    logic [N_REQ*WIDTH-1:0] wr_data;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [c_OWNER_W-1:0]   owner;
    logic                   busy;
    logic                   reg_load;
    logic                   reg_clear;
    logic [WIDTH-1:0]       reg_d;

    modport master (
        output req, op_clr, wr_data,
        input  gnt, ack, owner, busy, reg_load, reg_clear, reg_d
    );

    modport slave (
        input  req, op_clr, wr_data,
        output gnt, ack, owner, busy, reg_load, reg_clear, reg_d
    );
endinterface

`default_nettype wire

// File: rtl/reg_share_ctrl.sv
// ============================================================================
// Module      : reg_share_ctrl
// Description : Round-robin arbiter that serialises load/clear writes from
//               several requesters onto one shared storage register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            clear_n,
    reg_share_ctrl_if.slave bus
);
    localparam int                     c_OWNER_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_OWNER_W-1:0]   c_LAST_RST = c_OWNER_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]       c_ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_OWNER_W-1:0]   r_last;
    logic [c_OWNER_W-1:0]   r_owner;
    logic [N_REQ-1:0]       r_gnt;
    logic [N_REQ-1:0]       r_ack;
    logic                   r_busy;
    logic                   r_load;
    logic                   r_clear;
    logic [WIDTH-1:0]       r_d;

    state_t                 w_state;
    logic [c_OWNER_W-1:0]   w_last;
    logic [c_OWNER_W-1:0]   w_owner;
    logic [N_REQ-1:0]       w_gnt;
    logic [N_REQ-1:0]       w_ack;
    logic                   w_load;
    logic                   w_clear;
    logic [WIDTH-1:0]       w_d;
    logic                   w_found;
    logic [c_OWNER_W-1:0]   w_pick;
    logic [c_OWNER_W-1:0]   w_cand;

    // Search starts just past the last served requester, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = c_OWNER_W'((int'(r_last) + i) % N_REQ);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_owner = r_owner;
        w_last  = r_last;
        w_gnt   = '0;
        w_ack   = '0;
        w_load  = 1'b0;
        w_clear = 1'b0;
        w_d     = r_d;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state = S_GRANT;
                    w_owner = w_pick;
                    w_gnt   = c_ONE << w_pick;
                end
            end
            S_GRANT: begin
                // A requester that lets go during its grant forfeits the turn
                // without moving the round-robin pointer.
                if (bus.req[r_owner]) begin
                    w_state = S_WRITE;
                    w_d     = bus.wr_data[int'(r_owner)*WIDTH +: WIDTH];
                    w_load  = ~bus.op_clr[r_owner];
                    w_clear = bus.op_clr[r_owner];
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_WRITE: begin
                w_state = S_DONE;
                w_ack   = c_ONE << r_owner;
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_last  = r_owner;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // Reset drives reg_clear high so the shared register is wiped too.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_last  <= c_LAST_RST;
            r_owner <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_load  <= 1'b0;
            r_clear <= 1'b1;
            r_d     <= '0;
        end else begin
            r_state <= w_state;
            r_last  <= w_last;
            r_owner <= w_owner;
            r_gnt   <= w_gnt;
            r_ack   <= w_ack;
            r_busy  <= (w_state != S_IDLE);
            r_load  <= w_load;
            r_clear <= w_clear;
            r_d     <= w_d;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.ack       = r_ack;
    assign bus.owner     = r_owner;
    assign bus.busy      = r_busy;
    assign bus.reg_load  = r_load;
    assign bus.reg_clear = r_clear;
    assign bus.reg_d     = r_d;

endmodule

`default_nettype wire

// File: tb/tb_reg_share_ctrl.sv
// ============================================================================
// Module      : tb_reg_share_ctrl
// Description : Self-checking bench for reg_share_ctrl with a shared-register
//               model and a transaction-level round-robin reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_share_ctrl;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int OW = 2;

    logic clk;
    logic clear_n;
    logic mon_en;

    int   n_cmp;
    int   n_err;
    int   m_last;
    logic [W-1:0] m_q;
    logic [W-1:0] q;

    reg_share_ctrl_if #(.N_REQ(N), .WIDTH(W)) bus ();

    reg_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared storage register: clear has priority over load.
    always_ff @(posedge clk) begin
        if (bus.reg_clear)
            q <= '0;
        else if (bus.reg_load)
            q <= bus.reg_d;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (!$onehot0(bus.gnt) || !$onehot0(bus.ack) || (bus.reg_load && bus.reg_clear)) begin
                n_err++;
                $display("FAIL exclusivity: gnt=%b ack=%b load=%b clear=%b, required one-hot0 gnt/ack and not both load/clear",
                         bus.gnt, bus.ack, bus.reg_load, bus.reg_clear);
            end
        end
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int j = (last + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic apply_reset(input int edges);
        bus.req = '0;
        clear_n = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
        clear_n = 1'b1;
        @(posedge clk); #1;
        m_last = N - 1;
        m_q    = '0;
    endtask

    // One full transaction from IDLE, checked cycle by cycle against the model.
    task automatic run_txn(input logic [N-1:0] rv, input logic [N-1:0] ov, input logic [N*W-1:0] dv);
        int            j;
        logic [W-1:0]  dj;
        logic [N-1:0]  oh;
        logic [OW-1:0] jw;
        j  = rr_pick(rv, m_last);
        dj = dv[j*W +: W];
        oh = '0;
        oh[j] = 1'b1;
        jw = j[OW-1:0];
        bus.req = rv; bus.op_clr = ov; bus.wr_data = dv;

        @(posedge clk); #1;
        n_cmp++;
        if (bus.gnt !== oh || bus.owner !== jw || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL grant: gnt=%b owner=%0d busy=%b, required gnt=%b owner=%0d busy=1", bus.gnt, bus.owner, bus.busy, oh, j);
        end

        @(posedge clk); #1;
        n_cmp++;
        if (bus.gnt !== '0 || bus.reg_load !== ~ov[j] || bus.reg_clear !== ov[j] || bus.reg_d !== dj) begin
            n_err++;
            $display("FAIL write: gnt=%b load=%b clear=%b d=%h, required gnt=0 load=%b clear=%b d=%h",
                     bus.gnt, bus.reg_load, bus.reg_clear, bus.reg_d, ~ov[j], ov[j], dj);
        end
        m_q = ov[j] ? '0 : dj;

        @(posedge clk); #1;
        n_cmp++;
        if (bus.ack !== oh || q !== m_q || bus.reg_load !== 1'b0 || bus.reg_clear !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL done: ack=%b q=%h load=%b clear=%b busy=%b, required ack=%b q=%h load=0 clear=0 busy=1",
                     bus.ack, q, bus.reg_load, bus.reg_clear, bus.busy, oh, m_q);
        end
        bus.req[j] = 1'b0;

        @(posedge clk); #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.gnt !== '0 || bus.reg_d !== dj) begin
            n_err++;
            $display("FAIL idle: busy=%b ack=%b gnt=%b d=%h, required busy=0 ack=0 gnt=0 d=%h", bus.busy, bus.ack, bus.gnt, bus.reg_d, dj);
        end
        m_last = j;
    endtask

    task automatic test_reset();
        run_txn(4'b0001, 4'b0000, {4'h0, 4'h0, 4'h0, 4'hF});
        bus.req = '0;
        n_cmp++;
        if (q !== 4'hF) begin
            n_err++;
            $display("FAIL preload: q=%h, required F", q);
        end
        clear_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.reg_clear !== 1'b1 || bus.gnt !== '0 || bus.ack !== '0 || bus.busy !== 1'b0 ||
            bus.reg_load !== 1'b0 || bus.reg_d !== '0 || bus.owner !== '0) begin
            n_err++;
            $display("FAIL reset_vals: clear=%b gnt=%b ack=%b busy=%b load=%b d=%h owner=%0d, required clear=1 rest 0",
                     bus.reg_clear, bus.gnt, bus.ack, bus.busy, bus.reg_load, bus.reg_d, bus.owner);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q !== '0) begin
            n_err++;
            $display("FAIL reset_q: q=%h, required 0", q);
        end
        @(posedge clk); #1;
        clear_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.reg_clear !== 1'b0 || bus.gnt !== '0 || bus.ack !== '0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: clear=%b gnt=%b ack=%b busy=%b, required all 0",
                     bus.reg_clear, bus.gnt, bus.ack, bus.busy);
        end
        m_last = N - 1;
        m_q    = '0;
    endtask

    task automatic test_single_load();
        run_txn(4'b0100, 4'b0000, {4'h0, 4'h9, 4'h0, 4'h0});
        bus.req = '0;
    endtask

    task automatic test_clear_op();
        run_txn(4'b0001, 4'b0001, {4'h7, 4'h6, 4'h5, 4'hA});
        bus.req = '0;
    endtask

    task automatic test_round_robin();
        logic [N*W-1:0] dv;
        dv = {4'h4, 4'h3, 4'h2, 4'h1};
        apply_reset(2);
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 4'b0000, dv);
            n_cmp++;
            if (int'(bus.owner) !== (i % N) || q !== W'((i % N) + 1)) begin
                n_err++;
                $display("FAIL rr_order: step %0d owner=%0d q=%h, required owner=%0d q=%0d", i, bus.owner, q, i % N, (i % N) + 1);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_abort();
        apply_reset(2);
        bus.req = 4'b0010; bus.op_clr = '0; bus.wr_data = {4'h0, 4'h0, 4'hC, 4'h0};
        @(posedge clk); #1;
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL abort_grant: gnt=%b, required 0010", bus.gnt);
        end
        bus.req = '0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.reg_load !== 1'b0 || bus.ack !== '0) begin
            n_err++;
            $display("FAIL abort_idle: gnt=%b busy=%b load=%b ack=%b, required all 0", bus.gnt, bus.busy, bus.reg_load, bus.ack);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.reg_load !== 1'b0 || bus.ack !== '0 || q !== '0) begin
            n_err++;
            $display("FAIL abort_nowrite: load=%b ack=%b q=%h, required 0 0 0", bus.reg_load, bus.ack, q);
        end
        run_txn(4'b0011, 4'b0000, {4'h0, 4'h0, 4'hB, 4'hD});
        bus.req = '0;
        n_cmp++;
        if (bus.owner !== 2'd0) begin
            n_err++;
            $display("FAIL abort_last: owner=%0d, required 0", bus.owner);
        end
    endtask

    task automatic test_mid_reset();
        int acks;
        acks = 0;
        bus.req = 4'b0100; bus.op_clr = '0; bus.wr_data = {4'h0, 4'h5, 4'h0, 4'h0};
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.reg_load !== 1'b1 || bus.reg_d !== 4'h5) begin
            n_err++;
            $display("FAIL mid_write: load=%b d=%h, required load=1 d=5", bus.reg_load, bus.reg_d);
        end
        clear_n = 1'b0;
        bus.req = '0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ack !== '0 || bus.gnt !== '0 || bus.busy !== 1'b0 || bus.reg_load !== 1'b0 ||
            bus.reg_clear !== 1'b1 || bus.reg_d !== '0 || bus.owner !== '0) begin
            n_err++;
            $display("FAIL mid_reset_vals: ack=%b gnt=%b busy=%b load=%b clear=%b d=%h owner=%0d, required clear=1 rest 0",
                     bus.ack, bus.gnt, bus.busy, bus.reg_load, bus.reg_clear, bus.reg_d, bus.owner);
        end
        @(posedge clk); #1;
        clear_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.ack !== '0) acks++;
        end
        n_cmp++;
        if (acks != 0 || q !== '0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_after: acks=%0d q=%h busy=%b, required acks=0 q=0 busy=0", acks, q, bus.busy);
        end
        m_last = N - 1;
        m_q    = '0;
    endtask

    task automatic test_random();
        logic [N-1:0]   rv;
        logic [N-1:0]   ov;
        logic [N*W-1:0] dv;
        for (int t = 0; t < 24; t++) begin
            rv = N'($urandom_range(1, (1 << N) - 1));
            ov = N'($urandom);
            dv = (N*W)'($urandom);
            run_txn(rv, ov, dv);
            bus.req = '0;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; mon_en = 1'b0;
        m_last = N - 1; m_q = '0;
        bus.req = '0; bus.op_clr = '0; bus.wr_data = '0;
        clear_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        test_reset();
        test_single_load();
        test_clear_op();
        test_round_robin();
        test_abort();
        test_mid_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
